// File: rtl/cpu_pkg.sv
// Shared CPU package: architectural widths, register-index and scoreboard
// counter types, and the counter saturation limit.
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int SB_MAX = 3;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [1:0]    sb_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: in-flight write counter for one architectural register.
//   clk, rst_n      : clock, synchronous active-low reset
//   inc             : an instruction writing this register issues
//   dec_wb          : a write to this register retires at write-back
//   dec_kill        : a squashed writer to this register will never retire
//   cnt             : current count of pending writes
//   ovf, unf        : this cycle's update saturated high / clamped low
module sb_counter
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    inc,
  input  logic    dec_wb,
  input  logic    dec_kill,
  output sb_cnt_t cnt,
  output logic    ovf,
  output logic    unf
);
  sb_cnt_t    cnt_q, cnt_d;
  logic [3:0] sum;

  // Net sum spans -2..4, so a 4-bit two's-complement value holds it exactly.
  always_comb begin
    sum   = {2'b00, cnt_q} + {3'b000, inc} - {3'b000, dec_wb} - {3'b000, dec_kill};
    unf   = sum[3];
    ovf   = !sum[3] && (sum > 4'(SB_MAX));
    cnt_d = sum[1:0];
    if (unf)      cnt_d = '0;
    else if (ovf) cnt_d = sb_cnt_t'(SB_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register in-flight
// write counters that flag RAW hazards at ID.
//   clk, rst_n                 : clock, synchronous active-low reset
//   wb_rf_we, wb_WR, wb_data   : write-back port; a write also retires one
//                                pending write to wb_WR
//   id_rs1, id_rs2             : ID source indices
//   rd1, rd2                   : operand data (combinational)
//   busy1, busy2, stall        : source has an unresolved pending write
//   iss_valid, iss_we, iss_rd  : instruction leaving ID that writes iss_rd
//   kill_valid, kill_rd        : squashed writer that will never retire
//   sb_ovf, sb_unf             : sticky counter overflow / underflow
// Optional feature macro: RF_BYPASS_EN forwards the write-back data to a
// same-cycle read and hides busy when that write resolves the last pending one.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_rf_we,
  input  logic [AW-1:0]   wb_WR,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  output logic            stall,
  input  logic            iss_valid,
  input  logic            iss_we,
  input  logic [AW-1:0]   iss_rd,
  input  logic            kill_valid,
  input  logic [AW-1:0]   kill_rd,
  output logic            sb_ovf,
  output logic            sb_unf
);
  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wb_rf_we && wb_WR != '0) regs_d[wb_WR] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Scoreboard: x0 is never counted, so its slot is tied to zero.
  sb_cnt_t [NREG-1:0] cnt;
  logic    [NREG-1:0] ovf_v, unf_v;

  assign cnt[0]   = '0;
  assign ovf_v[0] = 1'b0;
  assign unf_v[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    sb_counter u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (iss_valid && iss_we && iss_rd == AW'(r)),
      .dec_wb   (wb_rf_we && wb_WR == AW'(r)),
      .dec_kill (kill_valid && kill_rd == AW'(r)),
      .cnt      (cnt[r]),
      .ovf      (ovf_v[r]),
      .unf      (unf_v[r])
    );
  end

  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (|ovf_v);
    unf_d = unf_q | (|unf_v);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign sb_ovf = ovf_q;
  assign sb_unf = unf_q;

  // Two identical read ports.
  logic [1:0][AW-1:0]   rs;
  logic [1:0][XLEN-1:0] rd;
  logic [1:0]           busy;

  assign rs = {id_rs2, id_rs1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
`ifdef RF_BYPASS_EN
    logic wb_hit;
    assign wb_hit  = wb_rf_we && wb_WR == rs[p] && rs[p] != '0;
    assign rd[p]   = wb_hit ? wb_data : regs_q[rs[p]];
    // The retiring write is the only one pending, and its data is forwarded.
    assign busy[p] = cnt[rs[p]] != '0 && !(wb_hit && cnt[rs[p]] == 2'd1);
`else
    assign rd[p]   = regs_q[rs[p]];
    assign busy[p] = cnt[rs[p]] != '0;
`endif
  end

  assign rd1   = rd[0];
  assign rd2   = rd[1];
  assign busy1 = busy[0];
  assign busy2 = busy[1];
  assign stall = busy1 | busy2;
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural integer register file for the 5-stage pipe: the sink of the write-back stage's `wb_rf_we`/`wb_WR`/`wb_data` write port, and the source of ID-stage operands. A per-register in-flight counter (scoreboard) tracks issued-but-not-retired writes and flags RAW hazards so ID can stall instead of reading stale data.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, register count; x0 hardwired zero
- `AW`, 5, register index width, log2(NREG)
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, synchronous, active-low
- `wb_rf_we` in 1: write-back write enable; also retires one pending write to `wb_WR`
- `wb_WR` in AW: write-back destination register
- `wb_data` in XLEN: write-back data
- `id_rs1`, `id_rs2` in AW: ID source indices
- `rd1`, `rd2` out XLEN: operand data, combinational
- `busy1`, `busy2` out 1: source has an unresolved pending write
- `stall` out 1: `busy1 | busy2`
- `iss_valid` in 1: an instruction leaves ID this cycle
- `iss_we`, `iss_rd` in 1/AW: issuing instruction writes `iss_rd`
- `kill_valid`, `kill_rd` in 1/AW: a squashed in-flight writer to `kill_rd` will never retire
- `sb_ovf`, `sb_unf` out 1: sticky counter overflow / underflow error

## Operation
- Storage: NREG-1 XLEN-bit registers (x1..x31); reading index 0 returns 0.
- Write: at posedge, if `wb_rf_we` and `wb_WR`≠0, `regs[wb_WR] <= wb_data`.
- Counter `cnt[r]`, 2 bits, for r=1..31, r=0 never counted.
  - inc = `iss_valid & iss_we & iss_rd==r & r≠0`
  - dec_wb = `wb_rf_we & wb_WR==r`; dec_kill = `kill_valid & kill_rd==r`
  - next = cnt + inc − dec_wb − dec_kill, evaluated as a net sum. Simultaneous inc and dec to the same r leaves cnt unchanged.
  - Result >3: cnt held at 3 and `sb_ovf` set. Result <0: cnt clamped to 0 and `sb_unf` set.
  - Both flags are sticky until reset.
- busyN: `cnt[id_rsN]≠0`, with the WB exception described under Configuration. Always 0 for index 0.
- `stall` does not gate internal updates; the ID stage must hold `iss_valid` low while `stall`=1.

## Timing
- Reads: zero latency (combinational from index, regs, and bypass path).
- Write visible to a non-bypassed read on the cycle after the WB cycle.
- Counter update at posedge; `busy` reflects the new count the following cycle.
- An issue in cycle N to rd=r makes `busy` for r assert in cycle N+1.
- Reset: all regs 0, all cnt 0, `sb_ovf`=`sb_unf`=0. Outputs follow: `rd1`=`rd2`=0, busy=stall=0.
- Reset mid-operation discards all pending state. No retire after reset may underflow silently: it sets `sb_unf`.

## Configuration
- `RF_BYPASS_EN` defined:
  - If `wb_rf_we`, `wb_WR`==`id_rsN`≠0, then `rdN`=`wb_data` in the same cycle.
  - busyN is suppressed when `cnt[id_rsN]`==1 and that same write retires this cycle.
- Not defined:
  - No bypass; rdN comes from storage only.
  - busyN = `cnt≠0` with no WB exception, so a dependent instruction stalls one cycle more.

## Structure
- Shared package `cpu_pkg`: `XLEN`, `AW`, `NREG`, `typedef logic [AW-1:0] reg_idx_t`, `typedef logic [1:0] sb_cnt_t`, `localparam SB_MAX=3`.
- One sub-module `sb_counter`: a single-register 2-bit up/down counter with inc, dec_wb, dec_kill, and saturation flags. It is instantiated 31×; the flags are OR-reduced into the sticky bits.

## Test plan
- Reset, then read x0..x31 → all 0. Write x0=0xDEAD → x0 still reads 0, cnt[0]=0.
- Write x5=0x1234 in cycle N, with `id_rs1`=5 in N:
  - With `RF_BYPASS_EN`, `rd1`=0x1234 in N.
  - Without it, `rd1`=0 in N and 0x1234 in N+1.
- Issue rd=7 in N → `busy1` for rs1=7 asserts in N+1. WB x7 in N+3:
  - With bypass, `busy1`=0 in N+3.
  - Without bypass, `busy1`=1 in N+3 and 0 in N+4.
- Same cycle: issue rd=3, WB x3 retires, cnt[3]=1 → cnt[3] stays 1, `busy` still 1.
- Issue rd=9 four times without a retire → cnt=3, `sb_ovf`=1 (sticky). WB x10 with cnt=0 → `sb_unf`=1.
- Issue rd=4 then kill rd=4 → cnt back to 0, `busy` deasserts, no flag set. Assert reset mid-flight → all counters 0.
